// File: rtl/axi_stream_rr_arb_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | if_axi_stream : valid/ready beat stream with sop/eop/err/mod/ctl sidebands |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BYTS = 1
);
    localparam int c_MW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic                    rdy;
    logic                    val;
    logic                    sop;
    logic                    eop;
    logic                    err;
    logic [DAT_BYTS*8-1:0]   dat;
    logic [c_MW-1:0]         mod;
    logic [CTL_BYTS*8-1:0]   ctl;

    modport source (input rdy, output val, sop, eop, err, dat, mod, ctl);
    modport sink   (output rdy, input val, sop, eop, err, dat, mod, ctl);
endinterface
`default_nettype wire

// File: rtl/axi_stream_rr_arb.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | axi_stream_rr_arb : packet-level round-robin merge of NUM_IN streams onto  |
// | one registered output stream. Rev 1.0                                     |
// +---------------------------------------------------------------------------+
module axi_stream_rr_arb #(
    parameter int NUM_IN   = 4,
    parameter int DAT_BYTS = 8,
    parameter int CTL_BYTS = 1,
    parameter int TAG_CTL  = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    if_axi_stream.sink                    i_axi [NUM_IN],
    if_axi_stream.source                  o_axi,
    output logic [$clog2(NUM_IN)-1:0]     o_grant,
    output logic                          o_busy,
    output logic                          o_sop_err
);
    localparam int c_GW = $clog2(NUM_IN);
    localparam int c_DW = DAT_BYTS * 8;
    localparam int c_CW = CTL_BYTS * 8;
    localparam int c_MW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_LOCK = 1'b1;

    logic [NUM_IN-1:0] w_val;
    logic [NUM_IN-1:0] w_sop;
    logic [NUM_IN-1:0] w_eop;
    logic [NUM_IN-1:0] w_err;
    logic [NUM_IN-1:0] w_rdy;
    logic [c_DW-1:0]   w_dat [NUM_IN];
    logic [c_MW-1:0]   w_mod [NUM_IN];
    logic [c_CW-1:0]   w_ctl [NUM_IN];

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_GW-1:0]   r_grant;
    logic              r_first;
    logic              r_sop_err;
    logic              r_val;
    logic              r_sop;
    logic              r_eop;
    logic              r_err;
    logic [c_DW-1:0]   r_dat;
    logic [c_MW-1:0]   r_mod;
    logic [c_CW-1:0]   r_ctl;

    logic              w_out_free;
    logic              w_load;
    logic              w_any;
    logic [c_GW-1:0]   w_pick;
    logic [c_GW-1:0]   w_idx;
    logic [c_CW-1:0]   w_ctl_in;
    logic              w_busy;

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_in
            assign w_val[g]     = i_axi[g].val;
            assign w_sop[g]     = i_axi[g].sop;
            assign w_eop[g]     = i_axi[g].eop;
            assign w_err[g]     = i_axi[g].err;
            assign w_dat[g]     = i_axi[g].dat;
            assign w_mod[g]     = i_axi[g].mod;
            assign w_ctl[g]     = i_axi[g].ctl;
            assign i_axi[g].rdy = w_rdy[g];
        end
    endgenerate

    assign w_out_free = !r_val || o_axi.rdy;
    assign w_load     = (r_state == c_S_LOCK) && w_val[r_grant] && w_out_free;

    // Scan from farthest to nearest so the requester right after r_grant wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_grant;
        w_idx  = r_grant;
        for (int k = NUM_IN; k >= 1; k--) begin
            w_idx = c_GW'((int'(r_grant) + k) % NUM_IN);
            if (w_val[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    generate
        if (TAG_CTL != 0) begin : g_tag_on
            always_comb begin
                w_ctl_in             = w_ctl[r_grant];
                w_ctl_in[c_GW-1:0]   = r_grant;
            end
        end else begin : g_tag_off
            assign w_ctl_in = w_ctl[r_grant];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_any) w_state_nxt = c_S_LOCK;
            c_S_LOCK: if (w_load && w_eop[r_grant]) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy  = '0;
        w_busy = 1'b0;
        if (r_state == c_S_LOCK) begin
            w_busy         = 1'b1;
            w_rdy[r_grant] = w_out_free;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant   <= c_GW'(NUM_IN - 1);
            r_first   <= 1'b0;
            r_sop_err <= 1'b0;
            r_val     <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= '0;
            r_mod     <= '0;
            r_ctl     <= '0;
        end else begin
            if ((r_state == c_S_IDLE) && w_any) begin
                r_grant <= w_pick;
                r_first <= 1'b1;
            end
            r_sop_err <= w_load && r_first && !w_sop[r_grant];
            if (w_load) begin
                r_first <= 1'b0;
                r_val   <= 1'b1;
                r_sop   <= w_sop[r_grant];
                r_eop   <= w_eop[r_grant];
                r_err   <= w_err[r_grant];
                r_dat   <= w_dat[r_grant];
                r_mod   <= w_mod[r_grant];
                r_ctl   <= w_ctl_in;
            end else if (o_axi.rdy) begin
                r_val   <= 1'b0;
            end
        end
    end

    assign o_axi.val = r_val;
    assign o_axi.sop = r_sop;
    assign o_axi.eop = r_eop;
    assign o_axi.err = r_err;
    assign o_axi.dat = r_dat;
    assign o_axi.mod = r_mod;
    assign o_axi.ctl = r_ctl;
    assign o_grant   = r_grant;
    assign o_busy    = w_busy;
    assign o_sop_err = r_sop_err;
endmodule
`default_nettype wire

// File: tb/tb_axi_stream_rr_arb.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_axi_stream_rr_arb : directed self-checking bench for axi_stream_rr_arb |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_axi_stream_rr_arb;
    localparam int NUM_IN = 4;

    typedef struct packed {
        logic [63:0] dat;
        logic [2:0]  mod;
        logic        sop;
        logic        eop;
        logic        err;
        logic [7:0]  ctl;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic [31:0] cyc;
        logic [1:0]  grant;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sink_rdy = 1'b1;
    logic        rand_bp = 1'b0;
    logic [31:0] cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          sop_err_cnt = 0;
    int          stab_viol = 0;

    beat_t             srcq [NUM_IN][$];
    obs_t              outq [$];
    logic [NUM_IN-1:0] src_val = '0;
    logic [NUM_IN-1:0] src_rdy;
    logic [NUM_IN-1:0] acc_q = '0;
    beat_t             src_b [NUM_IN];

    logic [1:0] o_grant;
    logic       o_busy;
    logic       o_sop_err;

    logic [NUM_IN-1:0] t_val = '0;
    logic [NUM_IN-1:0] t_rdy;
    beat_t             t_b [NUM_IN];
    logic              t_sink_rdy = 1'b0;
    logic [1:0]        t_grant;
    logic              t_busy;
    logic              t_sop_err;

    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BYTS(8), .CTL_BYTS(1)) s_axi [NUM_IN] ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BYTS(1)) m_axi ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BYTS(1)) ts_axi [NUM_IN] ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BYTS(1)) tm_axi ();

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_src
            assign s_axi[g].val  = src_val[g];
            assign s_axi[g].sop  = src_b[g].sop;
            assign s_axi[g].eop  = src_b[g].eop;
            assign s_axi[g].err  = src_b[g].err;
            assign s_axi[g].dat  = src_b[g].dat;
            assign s_axi[g].mod  = src_b[g].mod;
            assign s_axi[g].ctl  = src_b[g].ctl;
            assign src_rdy[g]    = s_axi[g].rdy;
            assign ts_axi[g].val = t_val[g];
            assign ts_axi[g].sop = t_b[g].sop;
            assign ts_axi[g].eop = t_b[g].eop;
            assign ts_axi[g].err = t_b[g].err;
            assign ts_axi[g].dat = t_b[g].dat;
            assign ts_axi[g].mod = t_b[g].mod;
            assign ts_axi[g].ctl = t_b[g].ctl;
            assign t_rdy[g]      = ts_axi[g].rdy;
        end
    endgenerate

    assign m_axi.rdy  = sink_rdy;
    assign tm_axi.rdy = t_sink_rdy;

    axi_stream_rr_arb #(.NUM_IN(NUM_IN), .DAT_BYTS(8), .CTL_BYTS(1), .TAG_CTL(0)) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_axi     (s_axi),
        .o_axi     (m_axi),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_sop_err (o_sop_err)
    );

    axi_stream_rr_arb #(.NUM_IN(NUM_IN), .DAT_BYTS(8), .CTL_BYTS(1), .TAG_CTL(1)) u_tag (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_axi     (ts_axi),
        .o_axi     (tm_axi),
        .o_grant   (t_grant),
        .o_busy    (t_busy),
        .o_sop_err (t_sop_err)
    );

    function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e,
                                 input logic [2:0] m, input logic [7:0] c);
        beat_t b;
        b.dat = d; b.sop = s; b.eop = e; b.err = 1'b0; b.mod = m; b.ctl = c;
        return b;
    endfunction

    // Source model: pop what the DUT accepted, then present the new queue heads.
    always @(posedge clk) acc_q <= src_val & src_rdy;

    always @(negedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc_q[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                src_val[i] = 1'b1;
                src_b[i]   = srcq[i][0];
            end else begin
                src_val[i] = 1'b0;
                src_b[i]   = '0;
            end
        end
        sink_rdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: record accepted beats, count error pulses, check hold stability.
    logic  hold_v = 1'b0;
    beat_t hold_b;
    always @(posedge clk) begin
        obs_t o;
        cyc <= cyc + 1;
        if (!rst && m_axi.val && m_axi.rdy) begin
            o.b     = mk(m_axi.dat, m_axi.sop, m_axi.eop, m_axi.mod, m_axi.ctl);
            o.cyc   = cyc;
            o.grant = o_grant;
            outq.push_back(o);
        end
        if (o_sop_err) sop_err_cnt++;
        if (hold_v && !rst && (m_axi.val !== 1'b1 || m_axi.dat !== hold_b.dat ||
                               m_axi.sop !== hold_b.sop || m_axi.eop !== hold_b.eop))
            stab_viol++;
        hold_v = !rst && m_axi.val && !m_axi.rdy;
        hold_b = mk(m_axi.dat, m_axi.sop, m_axi.eop, m_axi.mod, m_axi.ctl);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 300; i++) begin
            if (outq.size() >= n) break;
            tick();
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (m_axi.val !== 1'b0) begin errors++; $display("FAIL reset_val: got %0b expected 0", m_axi.val); end
        checks++; if (o_grant !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d expected 3", o_grant); end
        checks++; if (o_busy !== 1'b0 || o_sop_err !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%0b sop_err=%0b expected 0/0", o_busy, o_sop_err); end
        checks++; if (src_rdy !== 4'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", src_rdy); end
        checks++; if (m_axi.dat !== 64'd0 || m_axi.ctl !== 8'd0) begin errors++; $display("FAIL reset_data: dat=%0h ctl=%0h expected 0", m_axi.dat, m_axi.ctl); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int base;
        logic [31:0] c0;
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
        base = outq.size();
        srcq[1].push_back(mk(64'h11, 1'b1, 1'b0, 3'd0, 8'h00));
        srcq[1].push_back(mk(64'h22, 1'b0, 1'b0, 3'd0, 8'h00));
        srcq[1].push_back(mk(64'h33, 1'b0, 1'b1, 3'd3, 8'h00));
        c0 = cyc;
        tick();
        checks++; if (o_grant !== 2'd1 || o_busy !== 1'b1) begin errors++; $display("FAIL single_grant: grant=%0d busy=%0b expected 1/1", o_grant, o_busy); end
        wait_out(base + 3);
        checks++; if (outq.size() != base + 3) begin errors++; $display("FAIL single_count: got %0d beats expected 3", outq.size() - base); end
        if (outq.size() >= base + 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outq[base+k].b.dat !== exp_d[k] || outq[base+k].b.sop !== (k == 0) ||
                    outq[base+k].b.eop !== (k == 2) || outq[base+k].cyc !== c0 + 2 + k) begin
                    errors++;
                    $display("FAIL single_beat%0d: dat=%0h sop=%0b eop=%0b cyc=%0d expected dat=%0h sop=%0b eop=%0b cyc=%0d",
                             k, outq[base+k].b.dat, outq[base+k].b.sop, outq[base+k].b.eop, outq[base+k].cyc,
                             exp_d[k], k == 0, k == 2, c0 + 2 + k);
                end
            end
            checks++; if (outq[base+2].b.mod !== 3'd3) begin errors++; $display("FAIL single_mod: got %0d expected 3", outq[base+2].b.mod); end
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b expected 0", o_busy); end
    endtask

    task automatic test_two();
        int base;
        logic [31:0] c0;
        logic [63:0] exp_d [4];
        logic [31:0] exp_c [4];
        reset_pulse();
        exp_d[0] = 64'hA0; exp_d[1] = 64'hA1; exp_d[2] = 64'hB0; exp_d[3] = 64'hB1;
        base = outq.size();
        srcq[0].push_back(mk(64'hA0, 1'b1, 1'b0, 3'd0, 8'h00));
        srcq[0].push_back(mk(64'hA1, 1'b0, 1'b1, 3'd0, 8'h00));
        srcq[2].push_back(mk(64'hB0, 1'b1, 1'b0, 3'd0, 8'h00));
        srcq[2].push_back(mk(64'hB1, 1'b0, 1'b1, 3'd0, 8'h00));
        c0 = cyc;
        exp_c[0] = c0 + 2; exp_c[1] = c0 + 3; exp_c[2] = c0 + 5; exp_c[3] = c0 + 6;
        wait_out(base + 4);
        checks++; if (outq.size() != base + 4) begin errors++; $display("FAIL two_count: got %0d beats expected 4", outq.size() - base); end
        if (outq.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (outq[base+k].b.dat !== exp_d[k] || outq[base+k].cyc !== exp_c[k]) begin
                    errors++;
                    $display("FAIL two_beat%0d: dat=%0h cyc=%0d expected dat=%0h cyc=%0d",
                             k, outq[base+k].b.dat, outq[base+k].cyc, exp_d[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_rotate();
        int base;
        reset_pulse();
        base = outq.size();
        for (int i = 0; i < NUM_IN; i++) begin
            srcq[i].push_back(mk(64'(i), 1'b1, 1'b1, 3'd0, 8'h00));
            srcq[i].push_back(mk(64'(i), 1'b1, 1'b1, 3'd0, 8'h00));
        end
        wait_out(base + 8);
        checks++; if (outq.size() != base + 8) begin errors++; $display("FAIL rotate_count: got %0d beats expected 8", outq.size() - base); end
        if (outq.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (outq[base+k].b.dat !== 64'(k % 4)) begin
                    errors++;
                    $display("FAIL rotate_seq%0d: got %0d expected %0d", k, outq[base+k].b.dat, k % 4);
                end
            end
            checks++;
            if (outq[base+7].cyc - outq[base].cyc !== 32'd14) begin
                errors++;
                $display("FAIL rotate_span: got %0d cycles expected 14", outq[base+7].cyc - outq[base].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int v0;
        beat_t sent [8];
        base = outq.size();
        v0   = stab_viol;
        for (int k = 0; k < 8; k++) begin
            sent[k] = mk({$urandom, $urandom}, k == 0, k == 7, (k == 7) ? 3'd5 : 3'd0, 8'h00);
            srcq[1].push_back(sent[k]);
        end
        rand_bp = 1'b1;
        wait_out(base + 8);
        rand_bp = 1'b0;
        checks++; if (outq.size() != base + 8) begin errors++; $display("FAIL bp_count: got %0d beats expected 8", outq.size() - base); end
        if (outq.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (outq[base+k].b !== sent[k]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got dat=%0h sop=%0b eop=%0b mod=%0d expected dat=%0h sop=%0b eop=%0b mod=%0d",
                             k, outq[base+k].b.dat, outq[base+k].b.sop, outq[base+k].b.eop, outq[base+k].b.mod,
                             sent[k].dat, sent[k].sop, sent[k].eop, sent[k].mod);
                end
            end
        end
        checks++; if (stab_viol != v0) begin errors++; $display("FAIL bp_stable: got %0d hold violations expected 0", stab_viol - v0); end
        tick();
        tick();
    endtask

    task automatic test_tag();
        t_b[3] = mk(64'h5A, 1'b1, 1'b1, 3'd0, 8'hF0);
        t_val[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_rdy[3]) break;
        end
        tick();
        t_val[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tm_axi.val) break;
            tick();
        end
        checks++; if (tm_axi.val !== 1'b1) begin errors++; $display("FAIL tag_val: got %0b expected 1", tm_axi.val); end
        checks++; if (tm_axi.ctl !== 8'hF3) begin errors++; $display("FAIL tag_ctl: got %0h expected f3", tm_axi.ctl); end
        checks++; if (tm_axi.dat !== 64'h5A || t_grant !== 2'd3) begin errors++; $display("FAIL tag_dat: dat=%0h grant=%0d expected 5a/3", tm_axi.dat, t_grant); end
    endtask

    task automatic test_sop_err();
        int base;
        int e0;
        base = outq.size();
        e0   = sop_err_cnt;
        srcq[1].push_back(mk(64'h77, 1'b0, 1'b0, 3'd0, 8'h00));
        srcq[1].push_back(mk(64'h78, 1'b1, 1'b0, 3'd0, 8'h00));
        srcq[1].push_back(mk(64'h79, 1'b0, 1'b1, 3'd0, 8'h00));
        wait_out(base + 3);
        tick();
        tick();
        checks++; if (sop_err_cnt - e0 != 1) begin errors++; $display("FAIL sop_err_pulses: got %0d expected 1", sop_err_cnt - e0); end
        checks++; if (outq.size() != base + 3) begin errors++; $display("FAIL sop_err_count: got %0d beats expected 3", outq.size() - base); end
        if (outq.size() >= base + 3) begin
            checks++;
            if (outq[base].b.dat !== 64'h77 || outq[base].b.sop !== 1'b0 ||
                outq[base+1].b.dat !== 64'h78 || outq[base+1].b.sop !== 1'b1 || outq[base+2].b.dat !== 64'h79) begin
                errors++;
                $display("FAIL sop_err_data: got %0h/%0b %0h/%0b %0h expected 77/0 78/1 79",
                         outq[base].b.dat, outq[base].b.sop, outq[base+1].b.dat, outq[base+1].b.sop, outq[base+2].b.dat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int base2;
        int eops;
        base = outq.size();
        for (int k = 0; k < 6; k++) srcq[2].push_back(mk(64'hC0 + 64'(k), k == 0, k == 5, 3'd0, 8'h00));
        wait_out(base + 2);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (m_axi.val !== 1'b0) begin errors++; $display("FAIL midrst_val: got %0b expected 0", m_axi.val); end
        checks++; if (src_rdy !== 4'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: rdy=%b busy=%0b expected 0000/0", src_rdy, o_busy); end
        for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (o_grant !== 2'd3) begin errors++; $display("FAIL midrst_grant: got %0d expected 3", o_grant); end
        eops = 0;
        for (int k = base; k < outq.size(); k++) if (outq[k].b.eop) eops++;
        checks++; if (eops != 0) begin errors++; $display("FAIL midrst_no_eop: got %0d eop beats expected 0", eops); end
        base2 = outq.size();
        srcq[1].push_back(mk(64'hD1, 1'b1, 1'b1, 3'd0, 8'h00));
        srcq[2].push_back(mk(64'hD2, 1'b1, 1'b1, 3'd0, 8'h00));
        wait_out(base2 + 2);
        checks++; if (outq.size() != base2 + 2) begin errors++; $display("FAIL midrst_count: got %0d beats expected 2", outq.size() - base2); end
        if (outq.size() >= base2 + 2) begin
            checks++;
            if (outq[base2].b.dat !== 64'hD1 || outq[base2+1].b.dat !== 64'hD2) begin
                errors++;
                $display("FAIL midrst_order: got %0h,%0h expected d1,d2", outq[base2].b.dat, outq[base2+1].b.dat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_IN; i++) begin
            src_b[i] = '0;
            t_b[i]   = '0;
        end
        test_reset();
        test_single();
        test_two();
        test_rotate();
        test_backpressure();
        test_tag();
        test_sop_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
